// File: rtl/fifo_tx_ctrl.sv
// Write-side flow controller for the channel FIFO: pauses pushes with hysteresis
// and parks accepted words in a small in-order hold buffer while it cannot launch.
module fifo_tx_ctrl #(
   parameter int BUS_SIZE   = 5,
   parameter int HOLD_ADDR  = 2,
   parameter int HOLD_DEPTH = 1 << HOLD_ADDR,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 src_valid,
   input  logic [BUS_SIZE-1:0]  src_data,
   output logic                 src_ready,
   input  logic                 pause,
   input  logic                 continua,
   input  logic                 fifo_error,
   output logic                 push,
   output logic [BUS_SIZE-1:0]  data_out,
   output logic                 valid_out,
   output logic                 paused,
   output logic [HOLD_ADDR:0]   hold_count,
   output logic [CNT_WIDTH-1:0] sent_count,
   output logic [CNT_WIDTH-1:0] stall_count,
   output logic                 tx_error
);

   typedef enum logic {ST_SEND, ST_PAUSED} state_t;

   localparam logic [HOLD_ADDR-1:0] PTR_ONE   = 1;
   localparam logic [HOLD_ADDR-1:0] PTR_LAST  = HOLD_ADDR'(HOLD_DEPTH - 1);
   localparam logic [HOLD_ADDR:0]   CNT_ONE   = 1;
   localparam logic [HOLD_ADDR:0]   DEPTH_CNT = (HOLD_ADDR + 1)'(HOLD_DEPTH);
   localparam logic [CNT_WIDTH-1:0] STAT_ONE  = 1;

   state_t                state_q, state_d;
   logic [BUS_SIZE-1:0]   hold_mem [HOLD_DEPTH];
   logic [HOLD_ADDR-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [HOLD_ADDR:0]    cnt_q, cnt_d;
   logic                  push_q, push_d;
   logic [BUS_SIZE-1:0]   data_q, data_d;
   logic [CNT_WIDTH-1:0]  sent_q, sent_d, stall_q, stall_d;
   logic                  err_q, err_d;
   logic                  accept, launch, hold_pop, hold_wr;

   function automatic logic [HOLD_ADDR-1:0] ptr_inc(input logic [HOLD_ADDR-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_ONE;
   endfunction

   // Ready depends only on registered occupancy, never on pause/continua.
   assign src_ready = (cnt_q != DEPTH_CNT);

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      push_d   = 1'b0;
      data_d   = data_q;
      sent_d   = sent_q;
      stall_d  = stall_q;
      err_d    = err_q | fifo_error;
      hold_pop = 1'b0;
      hold_wr  = 1'b0;

      accept = src_valid && src_ready;
      launch = (state_q == ST_SEND) && !pause;

      if (pause)
         state_d = ST_PAUSED;
      else if (state_q == ST_PAUSED && continua)
         state_d = ST_SEND;

      // Held words always go out before a new word may bypass, keeping order.
      if (launch && cnt_q != '0) begin
         push_d   = 1'b1;
         data_d   = hold_mem[rd_ptr_q];
         hold_pop = 1'b1;
         hold_wr  = accept;
      end else if (launch && accept) begin
         push_d   = 1'b1;
         data_d   = src_data;
      end else begin
         hold_wr  = accept;
      end

      if (hold_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (hold_wr)  wr_ptr_d = ptr_inc(wr_ptr_q);
      if (hold_wr && !hold_pop)
         cnt_d = cnt_q + CNT_ONE;
      else if (hold_pop && !hold_wr)
         cnt_d = cnt_q - CNT_ONE;

      if (push_d) sent_d = sent_q + STAT_ONE;
      if (state_q == ST_PAUSED && stall_q != '1) stall_d = stall_q + STAT_ONE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_SEND;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         push_q   <= 1'b0;
         data_q   <= '0;
         sent_q   <= '0;
         stall_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         push_q   <= push_d;
         data_q   <= data_d;
         sent_q   <= sent_d;
         stall_q  <= stall_d;
         err_q    <= err_d;
      end
   end

   // Storage needs no reset: cleared pointers make stale contents unreachable.
   always_ff @(posedge clk) begin
      if (!reset && hold_wr)
         hold_mem[wr_ptr_q] <= src_data;
   end

   assign push        = push_q;
   assign valid_out   = push_q;
   assign data_out    = data_q;
   assign paused      = (state_q == ST_PAUSED);
   assign hold_count  = cnt_q;
   assign sent_count  = sent_q;
   assign stall_count = stall_q;
   assign tx_error    = err_q;

endmodule

// File: tb/tb_fifo_tx_ctrl.sv
// Directed bench for fifo_tx_ctrl: a queue-based reference model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_fifo_tx_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       src_valid;
   logic [4:0] src_data;
   logic       src_ready;
   logic       pause, continua, fifo_error;
   logic       push;
   logic [4:0] data_out;
   logic       valid_out, paused;
   logic [2:0] hold_count;
   logic [7:0] sent_count, stall_count;
   logic       tx_error;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fifo_tx_ctrl dut (
      .clk(clk), .reset(reset), .src_valid(src_valid), .src_data(src_data),
      .src_ready(src_ready), .pause(pause), .continua(continua),
      .fifo_error(fifo_error), .push(push), .data_out(data_out),
      .valid_out(valid_out), .paused(paused), .hold_count(hold_count),
      .sent_count(sent_count), .stall_count(stall_count), .tx_error(tx_error)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: occupancy as a queue, paused as a flag.
   logic [4:0] m_hold[$];
   bit         m_paused = 0;
   bit         m_push = 0;
   logic [4:0] m_data = '0;
   logic [7:0] m_sent = '0;
   logic [7:0] m_stall = '0;
   bit         m_err = 0;
   bit         m_started = 0;
   bit         m_acc, m_launch;
   logic [4:0] pushed[$];

   always @(posedge clk) begin
      if (reset) begin
         m_hold.delete();
         m_paused = 0; m_push = 0; m_data = '0;
         m_sent = '0; m_stall = '0; m_err = 0;
      end else begin
         m_acc    = src_valid && (m_hold.size() != 4);
         m_launch = !m_paused && !pause;
         if (m_launch && m_hold.size() > 0) begin
            m_push = 1;
            m_data = m_hold.pop_front();
            if (m_acc) m_hold.push_back(src_data);
         end else if (m_launch && m_acc) begin
            m_push = 1;
            m_data = src_data;
         end else begin
            m_push = 0;
            if (m_acc) m_hold.push_back(src_data);
         end
         if (m_push) m_sent = m_sent + 8'd1;
         if (m_paused && m_stall != 8'hFF) m_stall = m_stall + 8'd1;
         if (fifo_error) m_err = 1;
         if (pause) m_paused = 1;
         else if (continua) m_paused = 0;
      end
      m_started = 1;
   end

   always @(negedge clk) begin
      if (m_started) begin
         chk("m_push",        32'(push),        32'(m_push));
         chk("m_valid_out",   32'(valid_out),   32'(m_push));
         chk("m_data_out",    32'(data_out),    32'(m_data));
         chk("m_paused",      32'(paused),      32'(m_paused));
         chk("m_hold_count",  32'(hold_count),  32'(m_hold.size()));
         chk("m_src_ready",   32'(src_ready),   32'(m_hold.size() != 4));
         chk("m_sent_count",  32'(sent_count),  32'(m_sent));
         chk("m_stall_count", 32'(stall_count), 32'(m_stall));
         chk("m_tx_error",    32'(tx_error),    32'(m_err));
         if (push) pushed.push_back(data_out);
      end
   end

   task automatic drive(input logic v, input logic [4:0] d, input logic p,
                        input logic c, input logic e);
      src_valid = v; src_data = d; pause = p; continua = c; fifo_error = e;
      @(negedge clk);
   endtask

   // Holds the word on the source until it is accepted, within a cycle budget.
   task automatic send_word(input logic [4:0] d, input logic p, input logic c);
      bit r;
      bit done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         r = src_ready;
         drive(1'b1, d, p, c, 1'b0);
         if (r) done = 1;
      end
      chk("send_accept", 32'(done), 32'd1);
   endtask

   logic [4:0] exp_seq [8];

   initial begin
      exp_seq = '{5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A, 5'h0B};
      reset = 1'b1;
      repeat (2) drive(1'b0, 5'h00, 1'b0, 1'b0, 1'b0);
      chk("rst_push", 32'(push), 32'd0);
      chk("rst_src_ready", 32'(src_ready), 32'd1);
      chk("rst_hold", 32'(hold_count), 32'd0);
      chk("rst_paused", 32'(paused), 32'd0);
      chk("rst_counts", 32'({sent_count, stall_count, tx_error}), 32'd0);
      reset = 1'b0;

      drive(1'b1, 5'h01, 1'b0, 1'b0, 1'b0);
      chk("s1_data", 32'({push, valid_out, data_out}), 32'h61);
      drive(1'b1, 5'h02, 1'b0, 1'b0, 1'b0);
      chk("s2_data", 32'({push, valid_out, data_out}), 32'h62);
      drive(1'b1, 5'h03, 1'b0, 1'b0, 1'b0);
      chk("s3_data", 32'({push, valid_out, data_out}), 32'h63);
      chk("s3_sent", 32'(sent_count), 32'd3);
      drive(1'b0, 5'h00, 1'b0, 1'b0, 1'b0);
      chk("idle_push", 32'(push), 32'd0);

      drive(1'b1, 5'h04, 1'b1, 1'b0, 1'b0);
      chk("pause_push", 32'(push), 32'd0);
      drive(1'b1, 5'h05, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 5'h06, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 5'h07, 1'b1, 1'b0, 1'b0);
      chk("full_hold", 32'(hold_count), 32'd4);
      chk("full_ready", 32'(src_ready), 32'd0);
      drive(1'b1, 5'h08, 1'b1, 1'b0, 1'b0);
      chk("full_hold2", 32'(hold_count), 32'd4);
      chk("full_stall", 32'(stall_count), 32'd4);

      repeat (3) begin
         drive(1'b1, 5'h08, 1'b0, 1'b0, 1'b0);
         chk("hyst_paused", 32'(paused), 32'd1);
         chk("hyst_push", 32'(push), 32'd0);
      end
      chk("hyst_stall", 32'(stall_count), 32'd7);

      pushed.delete();
      send_word(5'h08, 1'b0, 1'b1);
      send_word(5'h09, 1'b0, 1'b0);
      repeat (5) drive(1'b0, 5'h00, 1'b0, 1'b0, 1'b0);
      chk("drained_hold", 32'(hold_count), 32'd0);
      send_word(5'h0A, 1'b0, 1'b0);
      chk("bypass_a", 32'({push, data_out}), 32'h2A);
      send_word(5'h0B, 1'b0, 1'b0);
      chk("bypass_b", 32'({push, data_out}), 32'h2B);
      drive(1'b0, 5'h00, 1'b0, 1'b0, 1'b0);
      chk("order_len", 32'(pushed.size()), 32'd8);
      for (int i = 0; i < 8; i++)
         if (i < pushed.size()) chk("order_word", 32'(pushed[i]), 32'(exp_seq[i]));
      chk("resume_sent", 32'(sent_count), 32'd11);
      chk("resume_stall", 32'(stall_count), 32'd8);

      repeat (3) begin
         drive(1'b0, 5'h00, 1'b1, 1'b1, 1'b0);
         chk("both_paused", 32'(paused), 32'd1);
         chk("both_push", 32'(push), 32'd0);
      end
      drive(1'b0, 5'h00, 1'b0, 1'b1, 1'b0);
      chk("both_release", 32'(paused), 32'd0);

      drive(1'b0, 5'h00, 1'b0, 1'b0, 1'b1);
      chk("err_set", 32'(tx_error), 32'd1);
      repeat (2) drive(1'b0, 5'h00, 1'b0, 1'b0, 1'b0);
      chk("err_sticky", 32'(tx_error), 32'd1);
      drive(1'b1, 5'h0C, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 5'h0D, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 5'h0E, 1'b1, 1'b0, 1'b0);
      chk("pre_rst_hold", 32'(hold_count), 32'd3);

      reset = 1'b1;
      repeat (2) drive(1'b0, 5'h00, 1'b0, 1'b0, 1'b0);
      chk("flush_hold", 32'(hold_count), 32'd0);
      chk("flush_err", 32'(tx_error), 32'd0);
      chk("flush_state", 32'({push, paused, src_ready}), 32'd1);
      chk("flush_counts", 32'({sent_count, stall_count}), 32'd0);
      reset = 1'b0;
      pushed.delete();
      repeat (4) drive(1'b0, 5'h00, 1'b0, 1'b0, 1'b0);
      chk("flush_no_push", 32'(pushed.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
